// File: rtl/clk_div_monitor.sv
// Checker for an even-divided clock: measures period and high time of div_in in clk
// cycles, tracks lock against the expected ratio N, and flags errors and a stuck clock.
module clk_div_monitor #(
  parameter int N           = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_vld,
  output logic             lock,
  output logic             err,
  output logic             stuck
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  N_VAL    = CNT_W'(N);
  localparam logic [CNT_W-1:0]  HALF_VAL = CNT_W'(N / 2);
  localparam logic [CNT_W-1:0]  TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ds, ds_q, ds_d, rise;
  logic [CNT_W-1:0]       pcnt_q, pcnt_d;
  logic [CNT_W-1:0]       hcnt_q, hcnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_time_q, high_time_d;
  logic                   meas_vld_q, meas_vld_d;
  logic                   lock_q, lock_d;
  logic                   err_q, err_d;
  logic                   stuck_q, stuck_d;
  logic [GOOD_W-1:0]      good_q, good_d, good_inc;
  logic                   match, timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  assign ds       = sync_q[SYNC_STAGES-1];
  assign ds_d     = ds;
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], div_in};
  assign rise     = ds & ~ds_q;
  assign match    = (period_q == N_VAL) && (high_time_q == HALF_VAL);
  assign good_inc = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);
  assign timeout  = !rise && !stuck_q && (pcnt_q == TO_VAL);

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    hcnt_d      = hcnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    meas_vld_d  = 1'b0;
    err_d       = 1'b0;
    lock_d      = lock_q;
    stuck_d     = stuck_q;
    good_d      = good_q;

    // Judge the values captured last cycle; the FSM below may override on en/timeout.
    if (meas_vld_q) begin
      if (match) begin
        good_d = good_inc;
        lock_d = (good_inc == GOOD_MAX);
      end else begin
        good_d = '0;
        lock_d = 1'b0;
        err_d  = 1'b1;
      end
    end

    if (!en) begin
      state_d = IDLE;
      pcnt_d  = '0;
      hcnt_d  = '0;
      lock_d  = 1'b0;
      good_d  = '0;
      stuck_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pcnt_d  = '0;
          hcnt_d  = '0;
          lock_d  = 1'b0;
          good_d  = '0;
          state_d = WAIT_EDGE;
        end
        WAIT_EDGE, MEASURE: begin
          if (rise) begin
            if (state_q == MEASURE) begin
              period_d    = pcnt_q;
              high_time_d = hcnt_q;
              meas_vld_d  = 1'b1;
            end
            pcnt_d  = CNT_W'(1);
            hcnt_d  = CNT_W'(1);
            stuck_d = 1'b0;
            state_d = MEASURE;
          end else if (timeout) begin
            pcnt_d  = '0;
            hcnt_d  = '0;
            stuck_d = 1'b1;
            err_d   = 1'b1;
            lock_d  = 1'b0;
            good_d  = '0;
            state_d = WAIT_EDGE;
          end else begin
            pcnt_d = sat_inc(pcnt_q, 1'b1);
            hcnt_d = (state_q == MEASURE) ? sat_inc(hcnt_q, ds) : '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      ds_q        <= 1'b0;
      pcnt_q      <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      meas_vld_q  <= 1'b0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
      stuck_q     <= 1'b0;
      good_q      <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      ds_q        <= ds_d;
      pcnt_q      <= pcnt_d;
      hcnt_q      <= hcnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      meas_vld_q  <= meas_vld_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
      stuck_q     <= stuck_d;
      good_q      <= good_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign meas_vld  = meas_vld_q;
  assign lock      = lock_q;
  assign err       = err_q;
  assign stuck     = stuck_q;

endmodule
